// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcodes, arbiter state encoding and width defaults
package alu_pkg;

    localparam int DW_DEF  = 32;
    localparam int OPW_DEF = 4;

    localparam logic [3:0] ALU_AND = 4'h0;
    localparam logic [3:0] ALU_OR  = 4'h1;
    localparam logic [3:0] ALU_ADD = 4'h2;
    localparam logic [3:0] ALU_SUB = 4'h6;
    localparam logic [3:0] ALU_SLT = 4'h7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    // Widened to 32 bits so callers with any OPW can use it without a width clash.
    function automatic logic op_is_legal(input logic [31:0] op);
        return (op == 32'(ALU_AND)) || (op == 32'(ALU_OR))  ||
               (op == 32'(ALU_ADD)) || (op == 32'(ALU_SUB)) ||
               (op == 32'(ALU_SLT));
    endfunction

endpackage

// File: rtl/alu_rr_arbiter_rr_pick.sv
// rtl/alu_rr_arbiter_rr_pick.sv - combinational round-robin first-one finder
//   req_i : request vector
//   ptr_i : index with highest priority this cycle (must be < N)
//   gnt_o : one-hot grant (zero when no request)
//   idx_o : index of the granted bit (zero when no request)
module rr_pick #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o
);

    always_comb begin
        int  j;
        logic found;
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        j     = 0;
        // Walk from ptr upward with wrap; the first set bit wins.
        for (int k = 0; k < N; k++) begin
            j = int'(ptr_i) + k;
            if (j >= N) j = j - N;
            if (!found && req_i[j]) begin
                found    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/alu_rr_arbiter.sv
// rtl/alu_rr_arbiter.sv - round-robin sharing of one combinational ALU between NREQ requesters
//   clk, rst_n           : clock, asynchronous active-low reset
//   req_valid/req_ready  : per-requester request handshake, operands packed in req_a/req_b/req_op
//   rsp_valid/rsp_ready  : per-requester response handshake, shared rsp_res/rsp_zero/rsp_err
//   alu_in1/in2/ctr      : registered operands to the external ALU
//   alu_res/alu_zero     : ALU result captured during EXEC
//   busy                 : high whenever an operation is in flight
//   Optional macro ALU_ARB_OPCHECK_EN: reject illegal op codes with rsp_err instead of executing.
module alu_rr_arbiter
    import alu_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int DW   = DW_DEF,
    parameter int OPW  = OPW_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*DW-1:0]  req_a,
    input  logic [NREQ*DW-1:0]  req_b,
    input  logic [NREQ*OPW-1:0] req_op,
    output logic [NREQ-1:0]   rsp_valid,
    input  logic [NREQ-1:0]   rsp_ready,
    output logic [DW-1:0]     rsp_res,
    output logic              rsp_zero,
    output logic              rsp_err,
    output logic [DW-1:0]     alu_in1,
    output logic [DW-1:0]     alu_in2,
    output logic [OPW-1:0]    alu_ctr,
    input  logic [DW-1:0]     alu_res,
    input  logic              alu_zero,
    output logic              busy
);

    localparam int IW = $clog2(NREQ);

    arb_state_t      state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   grant_q, grant_d;
    logic [DW-1:0]   a_q, a_d, b_q, b_d;
    logic [OPW-1:0]  op_q, op_d;
    logic [DW-1:0]   res_q, res_d;
    logic            zero_q, zero_d;
    logic            err_q, err_d;

    logic [NREQ-1:0] pick_gnt;
    logic [IW-1:0]   pick_idx;
    logic [DW-1:0]   sel_a, sel_b;
    logic [OPW-1:0]  sel_op;
    logic            op_ok;

    rr_pick #(.N(NREQ), .IW(IW)) u_pick (
        .req_i (req_valid),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx)
    );

    assign sel_a  = req_a[int'(pick_idx)*DW +: DW];
    assign sel_b  = req_b[int'(pick_idx)*DW +: DW];
    assign sel_op = req_op[int'(pick_idx)*OPW +: OPW];

`ifdef ALU_ARB_OPCHECK_EN
    assign op_ok = op_is_legal(32'(sel_op));
`else
    assign op_ok = 1'b1;
`endif

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        res_d     = res_q;
        zero_d    = zero_q;
        err_d     = err_q;
        req_ready = '0;
        rsp_valid = '0;
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    req_ready = pick_gnt;
                    grant_d   = pick_idx;
                    if (op_ok) begin
                        a_d     = sel_a;
                        b_d     = sel_b;
                        op_d    = sel_op;
                        state_d = EXEC;
                    end else begin
                        // Rejected op: ALU inputs keep their previous values.
                        res_d   = '0;
                        zero_d  = 1'b0;
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            EXEC: begin
                res_d   = alu_res;
                zero_d  = alu_zero;
                err_d   = 1'b0;
                state_d = RESP;
            end
            RESP: begin
                rsp_valid[grant_q] = 1'b1;
                if (rsp_ready[grant_q]) begin
                    state_d = IDLE;
                    ptr_d   = (int'(grant_q) == NREQ - 1) ? '0 : grant_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            err_q   <= err_d;
        end
    end

    assign alu_in1  = a_q;
    assign alu_in2  = b_q;
    assign alu_ctr  = op_q;
    assign rsp_res  = res_q;
    assign rsp_zero = zero_q;
    assign rsp_err  = err_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// tb/tb_alu_rr_arbiter.sv - self-checking bench for alu_rr_arbiter with a transaction-level model
module tb_alu_rr_arbiter;

    localparam int NREQ = 2;
    localparam int DW   = 32;
    localparam int OPW  = 4;

`ifdef ALU_ARB_OPCHECK_EN
    localparam bit OPCHK = 1'b1;
`else
    localparam bit OPCHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NREQ-1:0]     req_valid = '0, req_ready, rsp_valid, rsp_ready = '0;
    logic [NREQ*DW-1:0]  req_a = '0, req_b = '0;
    logic [NREQ*OPW-1:0] req_op = '0;
    logic [DW-1:0]       rsp_res, alu_in1, alu_in2, alu_res;
    logic [OPW-1:0]      alu_ctr;
    logic                rsp_zero, rsp_err, alu_zero, busy;

    int errors = 0;
    int checks = 0;

    alu_rr_arbiter #(.NREQ(NREQ), .DW(DW), .OPW(OPW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_res(rsp_res), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_ctr(alu_ctr),
        .alu_res(alu_res), .alu_zero(alu_zero), .busy(busy)
    );

    function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        case (op)
            4'h0:    return a & b;
            4'h1:    return a | b;
            4'h2:    return a + b;
            4'h6:    return a - b;
            4'h7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit legal_op(input logic [3:0] op);
        return op inside {4'h0, 4'h1, 4'h2, 4'h6, 4'h7};
    endfunction

    function automatic int pick(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    assign alu_res  = alu_ref(alu_in1, alu_in2, alu_ctr);
    assign alu_zero = (alu_res == 32'd0);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Transaction-level model: phase 0 = free, 1 = ALU cycle, 2 = response offered.
    int          m_phase = 0;
    int          m_ptr = 0;
    int          m_grant = 0;
    logic [31:0] m_a = '0, m_b = '0, m_res = '0;
    logic [3:0]  m_op = '0;
    logic        m_z = 1'b0, m_err = 1'b0;
    int          grant_log[$];

    initial begin
        forever begin
            logic [NREQ-1:0] exp_ready, exp_rv;
            int w;
            @(negedge clk);
            if (!rst_n) begin
                chk("reset_outputs", 32'(|{req_ready, rsp_valid, rsp_res, rsp_zero, rsp_err,
                                          alu_in1, alu_in2, alu_ctr, busy}), 32'd0);
                m_phase = 0; m_ptr = 0; m_grant = 0;
                m_a = '0; m_b = '0; m_op = '0; m_res = '0; m_z = 1'b0; m_err = 1'b0;
                continue;
            end
            w = pick(req_valid, m_ptr);
            exp_ready = '0;
            exp_rv    = '0;
            if (m_phase == 0 && w >= 0) exp_ready[w] = 1'b1;
            if (m_phase == 2) exp_rv[m_grant] = 1'b1;
            chk("req_ready", 32'(req_ready), 32'(exp_ready));
            chk("req_ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
            chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
            chk("busy", 32'(busy), 32'(m_phase != 0));
            chk("alu_in1", alu_in1, m_a);
            chk("alu_in2", alu_in2, m_b);
            chk("alu_ctr", 32'(alu_ctr), 32'(m_op));
            if (m_phase == 2) begin
                chk("rsp_res", rsp_res, m_res);
                chk("rsp_zero", 32'(rsp_zero), 32'(m_z));
                chk("rsp_err", 32'(rsp_err), 32'(m_err));
            end
            // Advance to what must hold after the coming rising edge.
            if (m_phase == 0 && w >= 0) begin
                logic [31:0] a, b;
                logic [3:0]  op;
                a  = req_a[w*DW +: DW];
                b  = req_b[w*DW +: DW];
                op = req_op[w*OPW +: OPW];
                m_grant = w;
                grant_log.push_back(w);
                if (OPCHK && !legal_op(op)) begin
                    m_res = '0; m_z = 1'b0; m_err = 1'b1; m_phase = 2;
                end else begin
                    m_a = a; m_b = b; m_op = op;
                    m_res = alu_ref(a, b, op); m_z = (m_res == 0); m_err = 1'b0;
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                m_phase = 2;
            end else if (m_phase == 2 && rsp_ready[m_grant]) begin
                m_phase = 0;
                m_ptr = (m_grant + 1) % NREQ;
            end
        end
    end

    task automatic set_req(input int idx, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        req_a[idx*DW +: DW]    = a;
        req_b[idx*DW +: DW]    = b;
        req_op[idx*OPW +: OPW] = op;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; req_valid = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_ready(input int idx, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready[idx]) begin ok = 1'b1; break; end
        end
    endtask

    task automatic run_one(input string name, input int idx, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] op, input logic [31:0] er, input logic ez,
                           input logic ee, input int elat);
        bit ok;
        int lat;
        @(posedge clk); #1;
        set_req(idx, a, b, op);
        req_valid = '0; req_valid[idx] = 1'b1; rsp_ready = '1;
        wait_ready(idx, ok);
        chk({name, "_accept"}, 32'(ok), 32'd1);
        @(posedge clk); #1 req_valid = '0;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (rsp_valid[idx]) begin lat = i; break; end
        end
        chk({name, "_latency"}, 32'(lat), 32'(elat));
        chk({name, "_res"}, rsp_res, er);
        chk({name, "_zero"}, 32'(rsp_zero), 32'(ez));
        chk({name, "_err"}, 32'(rsp_err), 32'(ee));
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        logic [31:0] held;
        #3;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        run_one("add", 0, 32'hFFFF0000, 32'h00FFFF00, 4'h2, 32'h00FEFF00, 1'b0, 1'b0, 2);
        run_one("sub", 0, 32'hFFFF0000, 32'h00FFFF00, 4'h6, 32'hFEFF0100, 1'b0, 1'b0, 2);
        run_one("and", 0, 32'hFFFF0000, 32'h00FFFF00, 4'h0, 32'h00FF0000, 1'b0, 1'b0, 2);
        run_one("or",  0, 32'hFFFF0000, 32'h00FFFF00, 4'h1, 32'hFFFFFF00, 1'b0, 1'b0, 2);
        run_one("slt", 0, 32'hFFFF0000, 32'h00FFFF00, 4'h7, 32'h00000001, 1'b0, 1'b0, 2);
        run_one("zero", 0, 32'h12345678, 32'h12345678, 4'h6, 32'h00000000, 1'b1, 1'b0, 2);
`ifdef ALU_ARB_OPCHECK_EN
        run_one("illegal", 0, 32'h1234, 32'h5678, 4'h5, 32'h0, 1'b0, 1'b1, 1);
        chk("illegal_alu_ctr_kept", 32'(alu_ctr), 32'h6);
`else
        run_one("illegal", 0, 32'h1234, 32'h5678, 4'h5, 32'h0, 1'b1, 1'b0, 2);
        chk("illegal_alu_ctr", 32'(alu_ctr), 32'h5);
`endif

        // Contention from reset: grants must alternate starting at 0.
        do_reset();
        grant_log.delete();
        set_req(0, 32'h00000005, 32'h00000003, 4'h2);
        set_req(1, 32'h00000009, 32'h00000004, 4'h6);
        rsp_ready = '1;
        req_valid = '1;
        repeat (25) @(posedge clk);
        #1 req_valid = '0;
        chk("contention_count", 32'(grant_log.size() >= 6), 32'd1);
        for (int i = 0; i < 6 && i < grant_log.size(); i++)
            chk("contention_grant", 32'(grant_log[i]), 32'(i % 2));

        // Back-pressure on requester 1 with requester 0 waiting.
        do_reset();
        set_req(1, 32'hA5A5A5A5, 32'h0F0F0F0F, 4'h0);
        set_req(0, 32'h00000001, 32'h00000002, 4'h2);
        rsp_ready = 2'b01;
        req_valid = 2'b10;
        wait_ready(1, ok);
        chk("bp_accept", 32'(ok), 32'd1);
        @(posedge clk); #1 req_valid = 2'b11;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid[1]) begin ok = 1'b1; break; end
        end
        chk("bp_rsp_seen", 32'(ok), 32'd1);
        held = rsp_res;
        chk("bp_res_value", held, 32'hA5A5A5A5 & 32'h0F0F0F0F);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_rsp_valid_hold", 32'(rsp_valid), 32'b10);
            chk("bp_rsp_res_hold", rsp_res, held);
            chk("bp_req_ready_zero", 32'(req_ready), 32'd0);
        end
        @(posedge clk); #1 rsp_ready = 2'b11;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (req_ready != '0) begin ok = 1'b1; break; end
        end
        chk("bp_next_grant", 32'(req_ready), 32'b01);
        @(posedge clk); #1 req_valid = '0;
        repeat (4) @(posedge clk);

        // Reset during EXEC: drops the op and returns the pointer to 0.
        do_reset();
        run_one("pre_reset", 0, 32'd7, 32'd8, 4'h2, 32'd15, 1'b0, 1'b0, 2);
        set_req(1, 32'd100, 32'd1, 4'h6);
        req_valid = 2'b10; rsp_ready = '1;
        wait_ready(1, ok);
        chk("mid_accept", 32'(ok), 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0; req_valid = '0;
        #1;
        chk("async_reset_zero", 32'(|{req_ready, rsp_valid, rsp_res, rsp_zero, rsp_err,
                                      alu_in1, alu_in2, alu_ctr, busy}), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("no_stale_rsp", 32'(rsp_valid), 32'd0);
        end
        @(posedge clk); #1 req_valid = 2'b11;
        set_req(0, 32'd1, 32'd1, 4'h2);
        @(negedge clk);
        chk("ptr_after_reset", 32'(req_ready), 32'b01);
        @(posedge clk); #1 req_valid = '0;
        repeat (4) @(posedge clk);

        // Randomized traffic, checked cycle by cycle by the model.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            req_valid = NREQ'($urandom);
            rsp_ready = NREQ'($urandom);
            for (int r = 0; r < NREQ; r++) begin
                logic [3:0] op;
                case ($urandom_range(0, 5))
                    0: op = 4'h0;
                    1: op = 4'h1;
                    2: op = 4'h2;
                    3: op = 4'h6;
                    4: op = 4'h7;
                    default: op = 4'($urandom);
                endcase
                set_req(r, ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom, $urandom, op);
            end
        end
        @(posedge clk); #1 req_valid = '0; rsp_ready = '1;
        repeat (6) @(posedge clk);
        #1;
        chk("drain_idle", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_rr_arbiter.md
Name: alu_rr_arbiter

Overview:
Shares the single 32-bit ALU (In1, In2, 4-bit ALUCtr → Res, Zero) between NREQ requesters, for example a branch-compare unit and a debug/self-test port.
- Round-robin grant; operands and op are registered; the ALU result is captured and returned to the winner over a valid/ready response channel.
- Sits between the requesters and the ALU instance. The ALU itself stays combinational and external.

Parameters:
- NREQ, 2, number of requesters (2..8).
- DW, 32, operand/result width.
- OPW, 4, ALU control width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  request valid per requester
- req_ready  out  NREQ  request accepted (one-hot or zero)
- req_a  in  NREQ*DW  operand A, requester i at [i*DW +: DW]
- req_b  in  NREQ*DW  operand B, same packing
- req_op  in  NREQ*OPW  ALU control code, same packing
- rsp_valid  out  NREQ  response valid (one-hot or zero)
- rsp_ready  in  NREQ  requester accepts response
- rsp_res  out  DW  result, shared bus, meaningful where rsp_valid set
- rsp_zero  out  1  ALU Zero flag for the result
- rsp_err  out  1  illegal-op flag (see Optional Feature)
- alu_in1  out  DW  to ALU In1
- alu_in2  out  DW  to ALU In2
- alu_ctr  out  OPW  to ALU ALUCtr
- alu_res  in  DW  from ALU Res
- alu_zero  in  1  from ALU Zero
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, rr_ptr=0, grant=0.
  - All outputs 0: req_ready, rsp_valid, rsp_res, rsp_zero, rsp_err, alu_in1/alu_in2/alu_ctr, busy.
  - Reset mid-operation drops the in-flight op silently; no response is produced.
- FSM states: IDLE → EXEC → RESP → IDLE.
- IDLE:
  - If any req_valid, pick the first set bit searching from rr_ptr upward with wrap.
  - req_ready[winner]=1 combinationally in that same cycle; a transfer occurs on valid&ready.
  - On the edge: latch a/b/op and grant index, go to EXEC.
  - No valid requests: stay in IDLE, req_ready=0.
- EXEC (exactly 1 cycle):
  - alu_in1/alu_in2/alu_ctr driven from the latched registers. These hold their values outside EXEC and are not cleared.
  - On the edge: capture alu_res→rsp_res and alu_zero→rsp_zero, go to RESP.
- RESP:
  - rsp_valid[grant]=1. rsp_res, rsp_zero, rsp_err stay stable until handshake.
  - On rsp_ready[grant]=1: go to IDLE, rr_ptr=(grant+1) mod NREQ.
  - rsp_ready on other indices is ignored.
  - req_ready=0 in EXEC and RESP; no new acceptance until back in IDLE.
- Latency and throughput:
  - Accept to rsp_valid is 2 cycles.
  - With rsp_ready tied high, minimum issue interval is 3 cycles.
- Fairness: a continuously requesting requester is granted within NREQ grants.
- Simultaneous requests in IDLE are resolved by rr_ptr. A requester that drops valid before grant is simply skipped.
- Legal op codes: 0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT. The arbiter does not interpret results.
- The response is held indefinitely under back-pressure.

Optional Feature:
- Macro: ALU_ARB_OPCHECK_EN.
- When defined:
  - In IDLE, the accepted op is checked against {0,1,2,6,7}.
  - Illegal op: skip EXEC (IDLE→RESP directly), rsp_res=0, rsp_zero=0, rsp_err=1. alu_* outputs are not updated.
  - Legal op: rsp_err=0.
- When undefined:
  - All ops go to the ALU unchanged.
  - rsp_err is tied to 0.

Decomposition:
- Shared package alu_pkg holds:
  - opcode constants ALU_AND=4'h0, ALU_OR=4'h1, ALU_ADD=4'h2, ALU_SUB=4'h6, ALU_SLT=4'h7;
  - the state enum arb_state_t {IDLE, EXEC, RESP};
  - DW/OPW defaults.
- One sub-module, rr_pick: combinational round-robin first-one finder (inputs req vector and ptr; outputs one-hot grant and index), reusable for other shared resources.

Test Plan:
- Single request: requester 0 sends a=FFFF0000, b=00FFFF00, op=2, with rsp_ready high → rsp_valid[0] two cycles after accept, rsp_res=00FEFF00, rsp_zero=0. Then repeat with op 6, 0, 1, 7 → FEFF0100, 00FF0000, FFFFFF00, 00000001.
- Zero flag: a=b=12345678, op=6 → rsp_res=0, rsp_zero=1.
- Contention: both requesters valid continuously from reset → grants alternate 0,1,0,1; each response matches its own operands; req_ready is never asserted on both bits.
- Back-pressure: hold rsp_ready[1]=0 for 10 cycles during RESP → rsp_valid/rsp_res stable, req_ready stays 0 with requester 0 pending, requester 0 is granted after the release.
- Reset mid-op: assert rst_n=0 during EXEC → all outputs 0 asynchronously; after release no stale rsp_valid appears and rr_ptr=0.
- With ALU_ARB_OPCHECK_EN: op=4'h5 → response after 1 cycle with rsp_err=1, rsp_res=0, and alu_ctr unchanged. Without the macro → rsp_err stays 0.
